// File: rtl/de_write_buffer.sv
// de_write_buffer: write-combining FIFO between the circle drawing unit and the 32-bit framestore.
// Writes are queued and drained in order; reads wait for the queue to drain first.
module de_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_req,
    output logic              de_ack,
    input  logic [ADDR_W-1:0] de_addr,
    input  logic [3:0]        de_nbyte,
    input  logic              de_rnw,
    input  logic [31:0]       de_w_data,
    output logic [31:0]       de_r_data,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_nbyte,
    output logic              mem_rnw,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ, M_RDONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] f_addr  [DEPTH];
    logic [3:0]        f_nbyte [DEPTH];
    logic [31:0]       f_data  [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, last;
    logic [PW:0]       count;
    logic              merge, wr_acc, push, pop, read_go;
    logic [31:0]       lane_mask, merged;
    assign last      = wr_ptr - PW'(1);
    // The head is either being loaded or already out at memory, so it must never be merged into
    assign merge     = count != '0 && f_addr[last] == de_addr && last != rd_ptr;
    assign wr_acc    = de_req && !de_ack && !de_rnw && (merge || count < (PW+1)'(DEPTH));
    assign push      = wr_acc && !merge;
    assign pop       = state == M_WRITE && mem_ack;
    assign read_go   = state == M_IDLE && de_req && de_rnw && !de_ack && count == '0;
    assign lane_mask = {{8{~de_nbyte[3]}}, {8{~de_nbyte[2]}}, {8{~de_nbyte[1]}}, {8{~de_nbyte[0]}}};
    assign merged    = (f_data[last] & ~lane_mask) | (de_w_data & lane_mask);
    assign empty     = count == '0 && state == M_IDLE && !mem_req;
    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr]  <= de_addr;
            f_nbyte[wr_ptr] <= de_nbyte;
            f_data[wr_ptr]  <= de_w_data;
        end else if (wr_acc) begin
            f_nbyte[last] <= f_nbyte[last] & de_nbyte;
            f_data[last]  <= merged;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= M_IDLE;
            de_ack    <= 1'b0;
            de_r_data <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_nbyte <= 4'hF;
            mem_rnw   <= 1'b0;
            mem_wdata <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            de_ack <= wr_acc;
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            case (state)
                M_IDLE: begin
                    if (read_go) begin
                        mem_req   <= 1'b1;
                        mem_rnw   <= 1'b1;
                        mem_nbyte <= 4'h0;
                        mem_addr  <= de_addr;
                        state     <= M_READ;
                    end else if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_rnw   <= 1'b0;
                        mem_nbyte <= f_nbyte[rd_ptr];
                        mem_addr  <= f_addr[rd_ptr];
                        mem_wdata <= f_data[rd_ptr];
                        state     <= M_WRITE;
                    end
                end
                M_WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= M_IDLE;
                    end
                end
                M_READ: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        de_r_data <= mem_rdata;
                        state     <= M_RDONE;
                    end
                end
                default: begin
                    de_ack <= 1'b1;
                    state  <= M_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_de_write_buffer.sv
// tb_de_write_buffer: scoreboard bench for de_write_buffer.
// Expected memory transactions are queued by the stimulus and checked by an independent monitor.
module tb_de_write_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de_req = 1'b0, de_rnw = 1'b0;
    logic        de_ack;
    logic [17:0] de_addr = '0;
    logic [3:0]  de_nbyte = 4'hF;
    logic [31:0] de_w_data = '0, de_r_data;
    logic        mem_req, mem_rnw, empty;
    logic        mem_ack = 1'b0;
    logic [17:0] mem_addr;
    logic [3:0]  mem_nbyte;
    logic [31:0] mem_wdata, mem_rdata = '0;

    typedef struct {
        logic        rnw;
        logic [17:0] addr;
        logic [3:0]  nb;
        logic [31:0] d;
    } txn_t;
    txn_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0, errors = 0, ack_dbl = 0;
    bit          hold = 1'b0, rnd = 1'b0, free_mode = 1'b0, prev_ack = 1'b0;
    logic [31:0] rd_val = '0;
    int          lane_cnt[int];
    logic [7:0]  lane_val[int];
    int          px_x[$], px_y[$];
    bit          seen[int];

    de_write_buffer #(.DEPTH(4), .ADDR_W(18)) dut (
        .clk(clk), .rst_n(rst_n), .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr),
        .de_nbyte(de_nbyte), .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_nbyte(mem_nbyte),
        .mem_rnw(mem_rnw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .empty(empty)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle ack after a (possibly random) wait, suppressed while hold is set
    int dly = 0, cnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mem_rdata = '0;
            cnt = 0;
            dly = rnd ? int'($urandom_range(0, 5)) : 0;
        end else if (mem_req && !hold) begin
            if (cnt >= dly) begin
                mem_ack = 1'b1;
                mem_rdata = rd_val;
            end else cnt++;
        end
    end

    txn_t        t;
    logic [31:0] e;
    always @(negedge clk) begin
        if (!rst_n) prev_ack = 1'b0;
        else begin
            if (de_ack && prev_ack) ack_dbl++;
            prev_ack = de_ack;
            if (mem_req && mem_ack) begin
                if (free_mode) begin
                    for (int i = 0; i < 4; i++)
                        if (!mem_nbyte[i]) begin
                            lane_cnt[int'(mem_addr) * 4 + i] = lane_cnt.exists(int'(mem_addr) * 4 + i) ? lane_cnt[int'(mem_addr) * 4 + i] + 1 : 1;
                            lane_val[int'(mem_addr) * 4 + i] = mem_wdata[8*i +: 8];
                        end
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_unexpected got rnw=%b addr=%h nb=%b d=%h required none", mem_rnw, mem_addr, mem_nbyte, mem_wdata);
                    end else begin
                        t = exp_q.pop_front();
                        if (mem_rnw !== t.rnw || mem_addr !== t.addr || mem_nbyte !== t.nb || (!t.rnw && mem_wdata !== t.d)) begin
                            errors++;
                            $display("FAIL mem_txn got rnw=%b addr=%h nb=%b d=%h required rnw=%b addr=%h nb=%b d=%h",
                                     mem_rnw, mem_addr, mem_nbyte, mem_wdata, t.rnw, t.addr, t.nb, t.d);
                        end
                    end
                end
            end
            if (de_ack && de_rnw && rd_q.size() > 0) begin
                checks++;
                e = rd_q.pop_front();
                if (de_r_data !== e) begin
                    errors++;
                    $display("FAIL rd_data got %h required %h", de_r_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic rnw, input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
        exp_q.push_back('{rnw: rnw, addr: a, nb: nb, d: d});
    endtask

    task automatic de_access(input logic rnw, input logic [17:0] a, input logic [3:0] nb,
                             input logic [31:0] d, input int budget, output bit got);
        @(posedge clk);
        #1;
        de_req = 1'b1; de_rnw = rnw; de_addr = a; de_nbyte = nb; de_w_data = d;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (de_ack) got = 1'b1;
        end
        @(posedge clk);
        #1;
        de_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (empty) ok = 1'b1;
        end
        chk({name, "_drain"}, 32'(ok), 32'd1);
        chk({name, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_de_ack"}, 32'(de_ack), 32'd0);
        chk({name, "_de_r_data"}, de_r_data, 32'd0);
        chk({name, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_mem_nbyte"}, 32'(mem_nbyte), 32'hF);
        chk({name, "_mem_rnw"}, 32'(mem_rnw), 32'd0);
        chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({name, "_empty"}, 32'(empty), 32'd1);
    endtask

    task automatic add_px(input int x, input int y);
        if (!seen.exists(y * 64 + x)) begin
            seen[y * 64 + x] = 1'b1;
            px_x.push_back(x);
            px_y.push_back(y);
        end
    endtask

    initial begin
        bit got;
        int acks, mreq, x, y, d, key, total;
        logic [7:0] col;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        expect_txn(1'b0, 18'h00010, 4'b1110, 32'h0000003C);
        de_access(1'b0, 18'h00010, 4'b1110, 32'h0000003C, 20, got);
        chk("single_ack", 32'(got), 32'd1);
        wait_idle("single");

        hold = 1'b1;
        expect_txn(1'b0, 18'h00000, 4'b0000, 32'hA5A5A5A5);
        expect_txn(1'b0, 18'h00020, 4'b1100, 32'h11112211);
        de_access(1'b0, 18'h00000, 4'b0000, 32'hA5A5A5A5, 20, got);
        chk("comb_ack0", 32'(got), 32'd1);
        de_access(1'b0, 18'h00020, 4'b1110, 32'h11111111, 20, got);
        chk("comb_ack1", 32'(got), 32'd1);
        de_access(1'b0, 18'h00020, 4'b1101, 32'h22222222, 20, got);
        chk("comb_ack2", 32'(got), 32'd1);
        hold = 1'b0;
        wait_idle("comb");

        hold = 1'b1;
        for (int i = 0; i < 5; i++) expect_txn(1'b0, 18'h00100 + 18'(i), 4'b0000, 32'h50 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            de_access(1'b0, 18'h00100 + 18'(i), 4'b0000, 32'h50 + 32'(i), 20, got);
            chk("full_ack", 32'(got), 32'd1);
        end
        @(posedge clk);
        #1;
        de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00104; de_nbyte = 4'b0000; de_w_data = 32'h54;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (de_ack) acks++;
        end
        chk("full_withheld", acks, 32'd0);
        hold = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (de_ack) got = 1'b1;
        end
        @(posedge clk);
        #1;
        de_req = 1'b0;
        chk("full_ack5", 32'(got), 32'd1);
        wait_idle("full");

        hold = 1'b1;
        expect_txn(1'b0, 18'h00200, 4'b0000, 32'h01010101);
        expect_txn(1'b0, 18'h00201, 4'b0011, 32'hCAFE0000);
        expect_txn(1'b1, 18'h00030, 4'b0000, 32'h0);
        rd_q.push_back(32'hDEADBEEF);
        rd_val = 32'hDEADBEEF;
        de_access(1'b0, 18'h00200, 4'b0000, 32'h01010101, 20, got);
        chk("rd_wack0", 32'(got), 32'd1);
        de_access(1'b0, 18'h00201, 4'b0011, 32'hCAFE0000, 20, got);
        chk("rd_wack1", 32'(got), 32'd1);
        hold = 1'b0;
        de_access(1'b1, 18'h00030, 4'b0000, 32'h0, 60, got);
        chk("rd_ack", 32'(got), 32'd1);
        chk("rd_consumed", rd_q.size(), 32'd0);
        wait_idle("rd");
        rd_val = '0;

        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            de_access(1'b0, 18'h00300 + 18'(i), 4'b0000, 32'h77 + 32'(i), 20, got);
            chk("rstw_ack", 32'(got), 32'd1);
        end
        @(negedge clk);
        chk("rstw_busy", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        mreq = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_req) mreq++;
        end
        chk("rstw_no_write", mreq, 32'd0);
        chk("rstw_empty", 32'(empty), 32'd1);
        hold = 1'b0;

        x = 0; y = 3; d = 1 - 3;
        while (x <= y) begin
            add_px(10 + x, 10 + y); add_px(10 - x, 10 + y); add_px(10 + x, 10 - y); add_px(10 - x, 10 - y);
            add_px(10 + y, 10 + x); add_px(10 - y, 10 + x); add_px(10 + y, 10 - x); add_px(10 - y, 10 - x);
            x++;
            if (d < 0) d += 2 * x + 1;
            else begin
                y--;
                d += 2 * (x - y) + 1;
            end
        end
        free_mode = 1'b1;
        rnd = 1'b1;
        for (int i = 0; i < px_x.size(); i++) begin
            key = px_y[i] * 64 + px_x[i];
            col = 8'(key) ^ 8'h5A;
            de_access(1'b0, 18'(key >> 2), ~(4'b0001 << (key & 3)), {4{col}}, 200, got);
            chk("loop_ack", 32'(got), 32'd1);
        end
        wait_idle("loop");
        total = 0;
        foreach (lane_cnt[k]) total += lane_cnt[k];
        chk("loop_total_lanes", total, px_x.size());
        for (int i = 0; i < px_x.size(); i++) begin
            key = px_y[i] * 64 + px_x[i];
            chk("loop_lane_once", lane_cnt.exists(key) ? lane_cnt[key] : 0, 32'd1);
            chk("loop_lane_val", lane_val.exists(key) ? 32'(lane_val[key]) : 32'hFFFF, 32'(8'(key) ^ 8'h5A));
        end
        chk("ack_never_double", ack_dbl, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running required finished");
        $fatal(1);
    end
endmodule
